// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment driver: latches a value, converts it to per-digit glyphs
// (binary, hex or decimal via iterative double-dabble) and scans them onto a shared bus.
module seg7_scan_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value_i,
  input  logic [1:0]        mode_i,
  input  logic              blank_lz_i,
  input  logic              load_i,
  output logic              ready_o,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int NHEX = (WIDTH + 3) / 4;
  localparam int NBCD = (WIDTH * 30103) / 100000 + 1;
  localparam int BW   = 4 * NBCD;
  localparam int NN   = (WIDTH > DIGITS) ? WIDTH : DIGITS;
  localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW   = $clog2(WIDTH);

  localparam logic [6:0]        G_BLANK = 7'b0000000;
  localparam logic [6:0]        G_DASH  = 7'b0000001;
  localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_RST  = (ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]       sh_q, sh_n;
  logic [BW-1:0]          bcd_q, bcd_adj, bcd_n;
  logic [SW-1:0]          sc_q;
  logic                   lz_q;
  logic [DIGITS-1:0][6:0] digits_q, digits_d, built;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   wrap, accept, conv_last;
  logic [1:0]             b_mode;
  logic                   b_lz, ovf;
  logic [4*NHEX-1:0]      hexv;
  logic [3:0]             nib [NN];
  int unsigned            msd;
  logic [7:0]             seg_raw, seg_nx;
  logic [DIGITS-1:0]      an_raw, an_nx;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_i && mode_i == 2'b10) state_d = CONV;
      CONV:    if (sc_q == SW'(WIDTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_o = (state_q == IDLE);
  end

  assign accept    = load_i && ready_o;
  assign conv_last = (state_q == CONV) && (sc_q == SW'(WIDTH - 1));

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < NBCD; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
    end
    {bcd_n, sh_n} = {bcd_adj, sh_q} << 1;
  end

  // Glyph builder; the final conversion step feeds it directly so digits update on completion.
  always_comb begin
    b_mode = conv_last ? 2'b10 : mode_i;
    b_lz   = conv_last ? lz_q : blank_lz_i;
    hexv   = '0;
    hexv[WIDTH-1:0] = value_i;
    for (int unsigned k = 0; k < NN; k++) nib[k] = '0;
    case (b_mode)
      2'b00: for (int unsigned k = 0; k < WIDTH; k++) nib[k] = {3'b000, value_i[k]};
      2'b01: for (int unsigned k = 0; k < NHEX; k++)  nib[k] = hexv[4*k +: 4];
      2'b10: for (int unsigned k = 0; k < NBCD; k++)  nib[k] = bcd_n[4*k +: 4];
      default: ;
    endcase
    ovf = 1'b0;
    for (int unsigned k = DIGITS; k < NN; k++) begin
      if (nib[k] != 4'd0) ovf = 1'b1;
    end
    msd = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (nib[k] != 4'd0) msd = k;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b_mode == 2'b11)                          built[i] = G_BLANK;
      else if (ovf)                                 built[i] = G_DASH;
      else if (b_lz && b_mode != 2'b00 && i > msd)  built[i] = G_BLANK;
      else                                          built[i] = glyph(nib[i]);
    end
  end

  always_comb begin
    digits_d = digits_q;
    if ((state_q == IDLE && accept && mode_i != 2'b10) || conv_last) digits_d = built;
  end

  // Scan: seg/an both come from the next index and next digits, so they switch together.
  always_comb begin
    wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    seg_raw = {digits_d[idx_d], 1'b0};
    an_raw  = DIGITS'(1) << idx_d;
    seg_nx  = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    an_nx   = (ACTIVE_LOW != 0) ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_o    <= SEG_OFF;
      an_o     <= AN_RST;
      sh_q     <= '0;
      bcd_q    <= '0;
      sc_q     <= '0;
      lz_q     <= 1'b0;
    end else begin
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_o    <= seg_nx;
      an_o     <= an_nx;
      if (state_q == IDLE && accept) begin
        sh_q  <= value_i;
        bcd_q <= '0;
        sc_q  <= '0;
        lz_q  <= blank_lz_i;
      end else if (state_q == CONV) begin
        sh_q  <= sh_n;
        bcd_q <= bcd_n;
        sc_q  <= sc_q + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: loads push expected screens, a monitor checks
// strobe sequence, ready_o timing and the segment bus against an arithmetic display model.
module tb_seg7_scan_display;
  localparam int WIDTH = 8;
  localparam int DIGITS = 4;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] value_i = '0;
  logic [1:0]       mode_i = '0;
  logic             blank_lz_i = 1'b0;
  logic             load_i = 1'b0;
  logic             ready_o;
  logic [7:0]       seg_o;
  logic [DIGITS-1:0] an_o;

  always #5 clk = ~clk;

  seg7_scan_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .mode_i(mode_i), .blank_lz_i(blank_lz_i),
    .load_i(load_i), .ready_o(ready_o), .seg_o(seg_o), .an_o(an_o));

  typedef struct {
    int unsigned       id;
    int unsigned       acc;
    int unsigned       busy;
    int unsigned       span;
    logic [3:0][7:0]   exp;
    logic [3:0][7:0]   old;
  } exp_t;

  exp_t            sb[$];
  int unsigned     cyc = 0;
  int unsigned     k = 0;
  int unsigned     nid = 0;
  int              cmp = 0;
  int              bad = 0;
  bit              active = 0;
  logic [3:0][7:0] shown = '1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    k   <= rst ? 0 : k + 1;
  end

  // Screen as it should appear, active-low bus values per digit, from base-conversion rules.
  function automatic logic [3:0][7:0] model(input int unsigned v, input int unsigned m, input bit lz);
    logic [3:0][7:0] r;
    int unsigned base, rest, top;
    int unsigned d [4];
    logic [6:0] g;
    base = (m == 0) ? 2 : (m == 1) ? 16 : 10;
    rest = v;
    for (int i = 0; i < 4; i++) begin
      d[i] = rest % base;
      rest = rest / base;
    end
    top = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 4; i++) begin
      if (m == 3)                         g = 7'b0000000;
      else if (rest != 0)                 g = 7'b0000001;
      else if (lz && m != 0 && i > top)   g = 7'b0000000;
      else                                g = GLY[d[i]];
      r[i] = ~{g, 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int unsigned id, input logic [31:0] act, input logic [31:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s entry=%0d cyc=%0d actual=%h required=%h", nm, id, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t        cur;
    int unsigned rel, di;
    logic [3:0]  exp_an;
    forever begin
      @(negedge clk);
      di = (k / REFRESH_DIV) % DIGITS;
      if (cyc >= 1) begin
        exp_an = ~(4'b0001 << di);
        chk("an_o", 0, {28'd0, an_o}, {28'd0, exp_an});
      end
      if (!active && sb.size() > 0) begin
        cur = sb.pop_front();
        active = 1;
      end
      if (active && cyc >= cur.acc) begin
        rel = cyc - cur.acc;
        if (rel < cur.busy) begin
          chk("ready_busy", cur.id, {31'd0, ready_o}, 32'd0);
          chk("seg_hold", cur.id, {24'd0, seg_o}, {24'd0, cur.old[di]});
        end else begin
          if (rel == cur.busy) chk("ready_done", cur.id, {31'd0, ready_o}, 32'd1);
          chk("seg", cur.id, {24'd0, seg_o}, {24'd0, cur.exp[di]});
          if (rel + 1 >= cur.busy + cur.span) active = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || active) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || active) begin
      cmp++;
      bad++;
      $display("FAIL idle_timeout cyc=%0d actual=pending required=drained", cyc);
      sb.delete();
      active = 0;
    end
  endtask

  task automatic push_blank(input int unsigned acc);
    exp_t e;
    e.id = nid++; e.acc = acc; e.busy = 0; e.span = 16;
    e.exp = '1; e.old = shown;
    sb.push_back(e);
    shown = '1;
  endtask

  // Called at posedge+1; returns at posedge+1 so consecutive calls give back-to-back loads.
  task automatic do_load(input logic [7:0] v, input logic [1:0] m, input bit lz,
                         input int unsigned span, input bit inject);
    exp_t e;
    value_i = v; mode_i = m; blank_lz_i = lz; load_i = 1'b1;
    e.id = nid++; e.acc = cyc + 1; e.busy = (m == 2'b10) ? WIDTH : 0; e.span = span;
    e.old = shown; e.exp = model(v, m, lz);
    sb.push_back(e);
    shown = e.exp;
    @(posedge clk); #1;
    load_i = 1'b0;
    if (inject) begin
      repeat (2) @(posedge clk);
      #1;
      value_i = 8'($urandom); mode_i = 2'($urandom_range(0, 3)); blank_lz_i = 1'($urandom_range(0, 1));
      load_i = 1'b1;
      @(posedge clk); #1;
      load_i = 1'b0;
    end
  endtask

  task automatic abort_conv();
    value_i = 8'd200; mode_i = 2'b10; blank_lz_i = 1'b0; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push_blank(cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : stimulus
    logic [7:0] v;
    logic [1:0] m;
    bit         lz;
    repeat (2) @(posedge clk);
    #1;
    push_blank(cyc);
    rst = 1'b0;
    wait_idle(); do_load(8'h3C, 2'b01, 1'b1, 16, 1'b0);
    wait_idle(); do_load(8'd255, 2'b10, 1'b0, 16, 1'b1);
    wait_idle(); do_load(8'b0000_1010, 2'b00, 1'b0, 16, 1'b0);
    wait_idle(); do_load(8'h1A, 2'b00, 1'b0, 16, 1'b0);
    wait_idle(); do_load(8'd0, 2'b10, 1'b1, 16, 1'b0);
    wait_idle(); do_load(8'hA5, 2'b11, 1'b0, 16, 1'b0);
    wait_idle(); do_load(8'h4F, 2'b10, 1'b0, 16, 1'b0);
    wait_idle(); abort_conv();
    wait_idle(); do_load(8'h12, 2'b01, 1'b0, 1, 1'b0); do_load(8'hA7, 2'b01, 1'b1, 16, 1'b0);
    repeat (30) begin
      v  = 8'($urandom_range(0, 255));
      m  = 2'($urandom_range(0, 3));
      lz = 1'($urandom_range(0, 1));
      wait_idle();
      do_load(v, m, lz, 16, (m == 2'b10) && ($urandom_range(0, 1) == 1));
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    bad++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
